// File: rtl/spi_master.sv
// Byte-oriented SPI master, mode 0, MSB first, with programmable CS setup/hold/idle timing.
// Define SPI_MASTER_BURST_EN to allow gapless multi-byte frames under a single chip-select.
module spi_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 4
) (
   input  logic       sysclk,
   input  logic       iResetN,
   input  logic       iTxValid,
   input  logic [7:0] iTx,
   output logic       oTxReady,
   output logic       oRxValid,
   output logic [7:0] oRx,
   output logic       oBusy,
   output logic       oSPIClk,
   output logic       oSPIMOSI,
   input  logic       iSPIMISO,
   output logic       oSPICS
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

`ifdef SPI_MASTER_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   // Phase counter reload values: each interval counts down to zero
   localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
   localparam logic [15:0] SETUP_M1 = 16'(CS_SETUP - 1);
   localparam logic [15:0] HOLD_M1  = 16'(CS_HOLD - 1);
   localparam logic [15:0] IDLE_M1  = 16'(CS_IDLE - 1);
   localparam bit          DIV_IS_1 = (CLK_DIV == 1);

   state_t      r_state;
   logic [15:0] r_phase;
   logic [2:0]  r_bit;
   logic [7:0]  r_tx_sh;
   logic [7:0]  r_rx_sh;
   logic [7:0]  r_rx;
   logic        r_rx_valid;
   logic        r_tx_ready;
   logic        r_busy;
   logic        r_sclk;
   logic        r_mosi;
   logic        r_cs;

   logic        w_accept;
   logic        w_phase_end;
   logic        w_last_bit;

   assign w_accept    = iTxValid & r_tx_ready;
   assign w_phase_end = (r_phase == 16'd0);
   assign w_last_bit  = (r_bit == 3'd7);

   // Frame sequencer: owns every registered output and the shift registers
   always_ff @(posedge sysclk or negedge iResetN) begin
      if (!iResetN) begin
         r_state    <= ST_IDLE;
         r_phase    <= 16'd0;
         r_bit      <= 3'd0;
         r_tx_sh    <= 8'h00;
         r_rx_sh    <= 8'h00;
         r_rx       <= 8'h00;
         r_rx_valid <= 1'b0;
         r_tx_ready <= 1'b1;
         r_busy     <= 1'b0;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_cs       <= 1'b1;
      end else begin
         r_rx_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state    <= ST_SETUP;
                  r_phase    <= SETUP_M1;
                  r_tx_sh    <= iTx;
                  r_mosi     <= iTx[7];
                  r_cs       <= 1'b0;
                  r_busy     <= 1'b1;
                  r_tx_ready <= 1'b0;
               end else begin
                  r_tx_ready <= 1'b1;
               end
            end
            ST_SETUP: begin
               if (w_phase_end) begin
                  r_state <= ST_SHIFT;
                  r_phase <= DIV_M1;
                  r_bit   <= 3'd0;
               end else begin
                  r_phase <= r_phase - 16'd1;
               end
            end
            ST_SHIFT: begin
               if (w_phase_end) begin
                  r_phase <= DIV_M1;
                  if (!r_sclk) begin
                     r_sclk     <= 1'b1;
                     r_rx_sh    <= {r_rx_sh[6:0], iSPIMISO};
                     // A one-cycle high phase means the final SHIFT cycle starts right now
                     r_tx_ready <= BURST & w_last_bit & DIV_IS_1;
                  end else begin
                     r_sclk <= 1'b0;
                     if (w_last_bit) begin
                        r_rx       <= r_rx_sh;
                        r_rx_valid <= 1'b1;
                        r_tx_ready <= 1'b0;
                        if (w_accept) begin
                           r_tx_sh <= iTx;
                           r_mosi  <= iTx[7];
                           r_bit   <= 3'd0;
                        end else begin
                           r_state <= ST_HOLD;
                           r_phase <= HOLD_M1;
                        end
                     end else begin
                        r_bit   <= r_bit + 3'd1;
                        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                        r_mosi  <= r_tx_sh[6];
                     end
                  end
               end else begin
                  r_phase <= r_phase - 16'd1;
                  if (BURST && r_sclk && w_last_bit && (r_phase == 16'd1)) begin
                     r_tx_ready <= 1'b1;
                  end else begin
                     r_tx_ready <= r_tx_ready;
                  end
               end
            end
            ST_HOLD: begin
               if (w_phase_end) begin
                  r_state <= ST_GAP;
                  r_phase <= IDLE_M1;
                  r_cs    <= 1'b1;
               end else begin
                  r_phase <= r_phase - 16'd1;
               end
            end
            ST_GAP: begin
               if (w_phase_end) begin
                  r_state    <= ST_IDLE;
                  r_busy     <= 1'b0;
                  r_tx_ready <= 1'b1;
               end else begin
                  r_phase <= r_phase - 16'd1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_cs       <= 1'b1;
               r_sclk     <= 1'b0;
               r_busy     <= 1'b0;
               r_tx_ready <= 1'b1;
            end
         endcase
      end
   end

   assign oTxReady = r_tx_ready;
   assign oRxValid = r_rx_valid;
   assign oRx      = r_rx;
   assign oBusy    = r_busy;
   assign oSPIClk  = r_sclk;
   assign oSPIMOSI = r_mosi;
   assign oSPICS   = r_cs;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: loop-back, model peripheral, back-to-back/burst, fast divider.
module tb_spi_master;
   localparam int DIV   = 4;
   localparam int SETUP = 2;
   localparam int HOLD  = 2;
   localparam int IDLE  = 4;

   logic       sysclk = 1'b0;
   logic       rst_n;
   logic       tx_valid = 1'b0;
   logic [7:0] tx = 8'h00;
   logic       tx_ready, rx_valid, busy, sclk, mosi, miso, cs;
   logic [7:0] rx;
   logic       f_valid = 1'b0;
   logic [7:0] f_tx = 8'h00;
   logic       f_ready, f_rxv, f_busy, f_sclk, f_mosi, f_cs;
   logic [7:0] f_rx;

   logic       lb = 1'b1;
   logic [7:0] pbyte = 8'h00;
   logic [7:0] pbits = 8'h00;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   assign miso = lb ? mosi : pbits[7];

   spi_master #(.CLK_DIV(DIV), .CS_SETUP(SETUP), .CS_HOLD(HOLD), .CS_IDLE(IDLE)) dut (
      .sysclk(sysclk), .iResetN(rst_n), .iTxValid(tx_valid), .iTx(tx), .oTxReady(tx_ready),
      .oRxValid(rx_valid), .oRx(rx), .oBusy(busy), .oSPIClk(sclk), .oSPIMOSI(mosi),
      .iSPIMISO(miso), .oSPICS(cs));

   spi_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) dut_f (
      .sysclk(sysclk), .iResetN(rst_n), .iTxValid(f_valid), .iTx(f_tx), .oTxReady(f_ready),
      .oRxValid(f_rxv), .oRx(f_rx), .oBusy(f_busy), .oSPIClk(f_sclk), .oSPIMOSI(f_mosi),
      .iSPIMISO(f_mosi), .oSPICS(f_cs));

   // Bus monitor and model peripheral, sampled mid-cycle
   logic       prev_sclk = 1'b0, prev_cs = 1'b1, prev_rxv = 1'b0;
   int         cs_low_run = 0, cs_high_run = 0, last_cs_low = 0;
   int         rises = 0, frames = 0, rxv_bad = 0;
   logic       mosi_log[$];
   logic [7:0] rx_log[$];
   int         rise_cyc[$];
   int         gap_log[$];
   logic [7:0] tx_q[$];
   int         acc_q[$];

   always @(negedge sysclk) begin
      if (!cs && prev_cs) begin
         gap_log.push_back(cs_high_run);
         cs_low_run = 0;
      end
      if (cs && !prev_cs) begin
         last_cs_low = cs_low_run;
         frames++;
         cs_high_run = 0;
      end
      if (!cs) cs_low_run++; else cs_high_run++;
      if (sclk && !prev_sclk) begin
         rises++;
         mosi_log.push_back(mosi);
         rise_cyc.push_back(cyc);
      end
      if (cs) pbits = pbyte;
      else if (!sclk && prev_sclk) pbits = {pbits[6:0], 1'b0};
      if (rx_valid) begin
         rx_log.push_back(rx);
         if (prev_rxv || !(!sclk && prev_sclk)) rxv_bad++;
      end
      prev_sclk = sclk;
      prev_cs   = cs;
      prev_rxv  = rx_valid;
   end

   task automatic send_bytes(input string name);
      int i = 0;
      int guard = 0;
      acc_q.delete();
      @(negedge sysclk);
      tx = tx_q[0];
      tx_valid = 1'b1;
      while (i < tx_q.size() && guard < 5000) begin
         if (tx_ready) begin
            @(posedge sysclk);
            #1;
            acc_q.push_back(cyc);
            i++;
            if (i < tx_q.size()) tx = tx_q[i]; else tx_valid = 1'b0;
         end
         @(negedge sysclk);
         guard++;
      end
      tx_valid = 1'b0;
      checks++;
      if (i != tx_q.size()) begin
         failures++;
         $display("FAIL %s accept: accepted %0d bytes, required %0d", name, i, tx_q.size());
      end
   endtask

   task automatic wait_idle(input string name);
      int guard = 0;
      @(negedge sysclk);
      while (busy && guard < 2000) begin
         @(negedge sysclk);
         guard++;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s idle_timeout: busy=%b required 0", name, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      checks++; if (cs !== 1'b1)       begin failures++; $display("FAIL rst_cs: got %b required 1", cs); end
      checks++; if (sclk !== 1'b0)     begin failures++; $display("FAIL rst_sclk: got %b required 0", sclk); end
      checks++; if (mosi !== 1'b0)     begin failures++; $display("FAIL rst_mosi: got %b required 0", mosi); end
      checks++; if (rx !== 8'h00)      begin failures++; $display("FAIL rst_rx: got %h required 00", rx); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rxv: got %b required 0", rx_valid); end
      checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b required 1", tx_ready); end
      #2 rst_n = 1'b1;
      repeat (2) @(negedge sysclk);
   endtask

   task automatic test_loopback();
      logic [7:0] b;
      logic [7:0] got;
      int r0, m0, x0, c0, bad;
      lb = 1'b1;
      for (int n = 0; n < 4; n++) begin
         b = (n == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
         r0 = rises; m0 = mosi_log.size(); x0 = rx_log.size(); c0 = rise_cyc.size();
         tx_q = {b};
         send_bytes("loopback");
         wait_idle("loopback");
         checks++; if (rises - r0 != 8) begin failures++; $display("FAIL lb_rises: got %0d required 8", rises - r0); end
         got = 8'h00;
         for (int k = 0; k < 8; k++) got = (got << 1) | 8'(mosi_log[m0 + k]);
         checks++; if (got !== b) begin failures++; $display("FAIL lb_mosi_bits: got %h required %h", got, b); end
         checks++; if (rx_log.size() - x0 != 1) begin failures++; $display("FAIL lb_rxv_count: got %0d required 1", rx_log.size() - x0); end
         else begin
            checks++; if (rx_log[x0] !== b) begin failures++; $display("FAIL lb_rx: got %h required %h", rx_log[x0], b); end
         end
         bad = 0;
         for (int k = c0 + 1; k < rise_cyc.size(); k++) if (rise_cyc[k] - rise_cyc[k-1] != 2 * DIV) bad++;
         checks++; if (bad != 0) begin failures++; $display("FAIL lb_sclk_period: %0d bad periods required 0", bad); end
         checks++;
         if (rise_cyc[c0] - acc_q[0] + 1 != 1 + SETUP + DIV) begin
            failures++; $display("FAIL lb_first_rise: got cycle %0d required %0d", rise_cyc[c0] - acc_q[0] + 1, 1 + SETUP + DIV);
         end
         checks++; if (last_cs_low != SETUP + 16 * DIV + HOLD) begin failures++; $display("FAIL lb_cs_low: got %0d required %0d", last_cs_low, SETUP + 16 * DIV + HOLD); end
         checks++; if (mosi !== b[0]) begin failures++; $display("FAIL lb_mosi_hold: got %b required %b", mosi, b[0]); end
      end
      checks++; if (rxv_bad != 0) begin failures++; $display("FAIL rxv_align: %0d misaligned pulses required 0", rxv_bad); end
   endtask

   task automatic test_peripheral();
      logic [7:0] b;
      int x0;
      lb = 1'b0;
      for (int n = 0; n < 3; n++) begin
         pbyte = (n == 0) ? 8'h3C : 8'($urandom_range(0, 255));
         b     = (n == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         x0 = rx_log.size();
         tx_q = {b};
         send_bytes("periph");
         wait_idle("periph");
         checks++; if (rx_log.size() - x0 != 1) begin failures++; $display("FAIL per_rxv_count: got %0d required 1", rx_log.size() - x0); end
         checks++; if (rx !== pbyte) begin failures++; $display("FAIL per_rx: got %h required %h", rx, pbyte); end
         checks++; if (last_cs_low != 68) begin failures++; $display("FAIL per_cs_low: got %0d required 68", last_cs_low); end
      end
      lb = 1'b1;
   endtask

   task automatic test_midframe_reset();
      int x0;
      tx_q = {8'h5A};
      send_bytes("midrst");
      repeat (20) @(negedge sysclk);
      checks++; if (cs !== 1'b0) begin failures++; $display("FAIL mid_cs_low: got %b required 0", cs); end
      x0 = rx_log.size();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (cs !== 1'b1)       begin failures++; $display("FAIL mid_rst_cs: got %b required 1", cs); end
      checks++; if (sclk !== 1'b0)     begin failures++; $display("FAIL mid_rst_sclk: got %b required 0", sclk); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_rxv: got %b required 0", rx_valid); end
      @(negedge sysclk);
      #2 rst_n = 1'b1;
      @(negedge sysclk);
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL mid_ready: got %b required 1", tx_ready); end
      repeat (100) @(negedge sysclk);
      checks++; if (rx_log.size() != x0) begin failures++; $display("FAIL mid_no_rx: got %0d pulses required 0", rx_log.size() - x0); end
      checks++; if (cs !== 1'b1)        begin failures++; $display("FAIL mid_cs_idle: got %b required 1", cs); end
      checks++; if (rx !== 8'h00)       begin failures++; $display("FAIL mid_rx_cleared: got %h required 00", rx); end
   endtask

   task automatic test_back_to_back();
      int f0, x0, g0, bad;
      tx_q.delete();
      for (int k = 0; k < 5; k++) tx_q.push_back(8'($urandom_range(0, 255)));
      f0 = frames; x0 = rx_log.size(); g0 = gap_log.size();
      send_bytes("b2b");
      wait_idle("b2b");
      checks++; if (frames - f0 != 5) begin failures++; $display("FAIL b2b_frames: got %0d required 5", frames - f0); end
      checks++; if (rx_log.size() - x0 != 5) begin failures++; $display("FAIL b2b_rx_count: got %0d required 5", rx_log.size() - x0); end
      bad = 0;
      for (int k = 0; k < 5 && x0 + k < rx_log.size(); k++) if (rx_log[x0 + k] !== tx_q[k]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL b2b_rx_data: %0d wrong bytes required 0", bad); end
      bad = 0;
      for (int k = g0 + 1; k < gap_log.size(); k++) if (gap_log[k] < IDLE) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL b2b_cs_gap: %0d short gaps required 0", bad); end
      bad = 0;
      for (int k = 1; k < acc_q.size(); k++) if (acc_q[k] - acc_q[k-1] < SETUP + 16 * DIV + HOLD + IDLE + 1) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL b2b_accept_spacing: %0d early accepts required 0", bad); end
   endtask

   task automatic test_burst();
      int f0, r0, x0, bad;
      tx_q = {8'h01, 8'h02, 8'h03};
      f0 = frames; r0 = rises; x0 = rx_log.size();
      send_bytes("burst");
      wait_idle("burst");
      checks++; if (frames - f0 != 1) begin failures++; $display("FAIL burst_frames: got %0d required 1", frames - f0); end
      checks++; if (rises - r0 != 24) begin failures++; $display("FAIL burst_rises: got %0d required 24", rises - r0); end
      bad = 0;
      for (int k = 0; k < 3 && x0 + k < rx_log.size(); k++) if (rx_log[x0 + k] !== tx_q[k]) bad++;
      checks++; if (rx_log.size() - x0 != 3 || bad != 0) begin failures++; $display("FAIL burst_rx: %0d bytes, %0d wrong, required 3 and 0", rx_log.size() - x0, bad); end
      checks++; if (last_cs_low != SETUP + 48 * DIV + HOLD) begin failures++; $display("FAIL burst_cs_low: got %0d required %0d", last_cs_low, SETUP + 48 * DIV + HOLD); end
   endtask

   task automatic test_fast_div();
      logic [7:0] b, got;
      int n, first, last, frises, rxc, bad;
      logic prev;
      for (int t = 0; t < 2; t++) begin
         b = 8'($urandom_range(0, 255));
         @(negedge sysclk);
         f_tx = b; f_valid = 1'b1;
         @(posedge sysclk);
         #1 f_valid = 1'b0;
         n = 0; first = -1; last = 0; frises = 0; rxc = 0; bad = 0; got = 8'h00; prev = f_sclk;
         while (n < 60) begin
            @(negedge sysclk);
            n++;
            if (f_sclk && !prev) begin
               frises++;
               if (first < 0) first = n; else if (n - last != 2) bad++;
               last = n;
            end
            if (f_rxv) begin rxc++; got = f_rx; end
            prev = f_sclk;
            if (!f_busy) break;
         end
         checks++; if (first != 3)   begin failures++; $display("FAIL fast_first_rise: got %0d required 3", first); end
         checks++; if (frises != 8 || bad != 0) begin failures++; $display("FAIL fast_sclk: %0d rises %0d bad periods, required 8 and 0", frises, bad); end
         checks++; if (rxc != 1 || got !== b) begin failures++; $display("FAIL fast_rx: %0d pulses byte %h, required 1 and %h", rxc, got, b); end
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_peripheral();
      test_midframe_reset();
`ifdef SPI_MASTER_BURST_EN
      test_burst();
`else
      test_back_to_back();
`endif
      test_fast_div();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
